brq_wb_arbiter: RTL and testbench

Writeback-port arbiter for the brq core. It shares the single integer register-file write port and the single FP register-file write port among three result sources: LSU load return, single-cycle ID/EX results, and a multi-cycle unit (FPU/divider). Multi-cycle results are buffered in a small FIFO, and a starvation counter bounds their wait behind EX. The block sits between the execute/LSU units and the register files, feeding registered write strobes to both RFs.

---
 rtl/brq_wb_arbiter_if.sv | 50 +++++
 rtl/brq_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_brq_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/brq_wb_arbiter_if.sv
// rtl/brq_wb_arbiter_if.sv - writeback arbiter source/RF bundle
interface brq_wb_arbiter_if #(
    parameter int FifoDepth = 2
);
    localparam int CntW = $clog2(FifoDepth + 1);

    logic            lsu_we_i;
    logic            lsu_fp_i;
    logic [4:0]      lsu_waddr_i;
    logic [31:0]     lsu_wdata_i;
    logic            ex_valid_i;
    logic            ex_fp_i;
    logic [4:0]      ex_waddr_i;
    logic [31:0]     ex_wdata_i;
    logic            ex_ready_o;
    logic            mc_valid_i;
    logic            mc_fp_i;
    logic [4:0]      mc_waddr_i;
    logic [31:0]     mc_wdata_i;
    logic            mc_ready_o;
    logic            flush_i;
    logic            rf_we_o;
    logic [4:0]      rf_waddr_o;
    logic [31:0]     rf_wdata_o;
    logic            fp_rf_we_o;
    logic [4:0]      fp_rf_waddr_o;
    logic [31:0]     fp_rf_wdata_o;
    logic [CntW-1:0] mc_count_o;
    logic [1:0]      grant_o;

    modport slave (
        input  lsu_we_i, lsu_fp_i, lsu_waddr_i, lsu_wdata_i,
        input  ex_valid_i, ex_fp_i, ex_waddr_i, ex_wdata_i,
        input  mc_valid_i, mc_fp_i, mc_waddr_i, mc_wdata_i, flush_i,
        output ex_ready_o, mc_ready_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o,
        output fp_rf_we_o, fp_rf_waddr_o, fp_rf_wdata_o,
        output mc_count_o, grant_o
    );

    modport master (
        output lsu_we_i, lsu_fp_i, lsu_waddr_i, lsu_wdata_i,
        output ex_valid_i, ex_fp_i, ex_waddr_i, ex_wdata_i,
        output mc_valid_i, mc_fp_i, mc_waddr_i, mc_wdata_i, flush_i,
        input  ex_ready_o, mc_ready_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o,
        input  fp_rf_we_o, fp_rf_waddr_o, fp_rf_wdata_o,
        input  mc_count_o, grant_o
    );
endinterface

// File: rtl/brq_wb_arbiter.sv
// rtl/brq_wb_arbiter.sv - LSU/EX/multi-cycle writeback arbiter for int and FP RF ports
module brq_wb_arbiter #(
    parameter int FifoDepth   = 2,
    parameter int StarveLimit = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    brq_wb_arbiter_if.slave bus
);
    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW = $clog2(FifoDepth + 1);

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_LSU  = 2'd1;
    localparam logic [1:0] GNT_EX   = 2'd2;
    localparam logic [1:0] GNT_MC   = 2'd3;

    logic [37:0]     mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [CntW-1:0] count;
    logic [3:0]      starve_cnt;

    logic        nonempty, full, starve, push, pop, ex_win, mc_win;
    logic        sel_win, sel_fp;
    logic [4:0]  sel_waddr;
    logic [31:0] sel_wdata;
    logic [1:0]  sel_grant;
    logic [37:0] head;

    assign nonempty = (count != '0);
    assign full     = (count == CntW'(FifoDepth));
    assign starve   = (starve_cnt == 4'(StarveLimit));
    assign head     = mem[rd_ptr];

    assign bus.mc_ready_o = ~full & ~bus.flush_i;
    assign bus.ex_ready_o = ~bus.lsu_we_i & ~bus.flush_i & ~(nonempty & starve);
    assign bus.mc_count_o = count;

    // EX loses to MC only through ex_ready_o, which already folds in starvation
    assign push   = bus.mc_valid_i & bus.mc_ready_o;
    assign ex_win = bus.ex_valid_i & bus.ex_ready_o;
    assign mc_win = nonempty & ~bus.lsu_we_i & ~bus.flush_i & ~ex_win;
    assign pop    = mc_win;

    always_comb begin
        sel_win   = 1'b0;
        sel_fp    = 1'b0;
        sel_waddr = '0;
        sel_wdata = '0;
        sel_grant = GNT_NONE;
        if (bus.lsu_we_i) begin
            sel_win   = 1'b1;
            sel_fp    = bus.lsu_fp_i;
            sel_waddr = bus.lsu_waddr_i;
            sel_wdata = bus.lsu_wdata_i;
            sel_grant = GNT_LSU;
        end else if (ex_win) begin
            sel_win   = 1'b1;
            sel_fp    = bus.ex_fp_i;
            sel_waddr = bus.ex_waddr_i;
            sel_wdata = bus.ex_wdata_i;
            sel_grant = GNT_EX;
        end else if (mc_win) begin
            sel_win   = 1'b1;
            sel_fp    = head[37];
            sel_waddr = head[36:32];
            sel_wdata = head[31:0];
            sel_grant = GNT_MC;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {bus.mc_fp_i, bus.mc_waddr_i, bus.mc_wdata_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (bus.flush_i || pop || !nonempty) begin
            starve_cnt <= '0;
        end else if (!starve) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Address/data hold when idle; only the strobes and grant drop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.rf_we_o       <= 1'b0;
            bus.fp_rf_we_o    <= 1'b0;
            bus.rf_waddr_o    <= '0;
            bus.rf_wdata_o    <= '0;
            bus.fp_rf_waddr_o <= '0;
            bus.fp_rf_wdata_o <= '0;
            bus.grant_o       <= GNT_NONE;
        end else begin
            bus.rf_we_o    <= sel_win & ~sel_fp & (sel_waddr != 5'd0);
            bus.fp_rf_we_o <= sel_win & sel_fp;
            bus.grant_o    <= sel_grant;
            if (sel_win) begin
                bus.rf_waddr_o    <= sel_waddr;
                bus.rf_wdata_o    <= sel_wdata;
                bus.fp_rf_waddr_o <= sel_waddr;
                bus.fp_rf_wdata_o <= sel_wdata;
            end
        end
    end
endmodule

// File: tb/tb_brq_wb_arbiter.sv
// tb/tb_brq_wb_arbiter.sv - scoreboard bench for brq_wb_arbiter
module tb_brq_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic        fp;
        logic [4:0]  addr;
        logic [31:0] data;
        int          at;
    } wr_t;

    wr_t exp_q[$];

    brq_wb_arbiter_if #(.FifoDepth(2)) bus ();

    brq_wb_arbiter #(.FifoDepth(2), .StarveLimit(4)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic fp, input logic [4:0] addr, input logic [31:0] data);
        wr_t e;
        e.fp   = fp;
        e.addr = addr;
        e.data = data;
        e.at   = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        bus.lsu_we_i = 0; bus.lsu_fp_i = 0; bus.lsu_waddr_i = 0; bus.lsu_wdata_i = 0;
        bus.ex_valid_i = 0; bus.ex_fp_i = 0; bus.ex_waddr_i = 0; bus.ex_wdata_i = 0;
        bus.mc_valid_i = 0; bus.mc_fp_i = 0; bus.mc_waddr_i = 0; bus.mc_wdata_i = 0;
        bus.flush_i = 0;
    endtask

    task automatic drive_ex(input logic fp, input logic [4:0] addr, input logic [31:0] data);
        bus.ex_valid_i = 1; bus.ex_fp_i = fp; bus.ex_waddr_i = addr; bus.ex_wdata_i = data;
    endtask

    task automatic drive_mc(input logic fp, input logic [4:0] addr, input logic [31:0] data);
        bus.mc_valid_i = 1; bus.mc_fp_i = fp; bus.mc_waddr_i = addr; bus.mc_wdata_i = data;
    endtask

    // Monitor: every strobe must match the queue head, including its cycle
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rf_we_o || bus.fp_rf_we_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {26'd0, bus.rf_we_o, bus.fp_rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o}, 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_fields",
                        {26'd0, bus.rf_we_o, bus.fp_rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o},
                        {26'd0, ~e.fp, e.fp, e.addr, e.data});
                    chk("write_fp_port", {27'd0, bus.fp_rf_waddr_o, bus.fp_rf_wdata_o}, {27'd0, e.addr, e.data});
                    chk("write_cycle", 64'(cyc), 64'(e.at));
                end
            end
        end
    end

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", 64'(bus.rf_we_o), 64'd0);
        chk("rst_fp_we", 64'(bus.fp_rf_we_o), 64'd0);
        chk("rst_grant", 64'(bus.grant_o), 64'd0);
        chk("rst_count", 64'(bus.mc_count_o), 64'd0);
        chk("rst_mc_ready", 64'(bus.mc_ready_o), 64'd1);
        chk("rst_addr_data", {27'd0, bus.rf_waddr_o, bus.rf_wdata_o}, 64'd0);
        rst = 0;
        step(); step();

        // Three-way collision with one MC entry already buffered
        drive_mc(0, 5'd7, 32'h33);
        step();
        idle();
        bus.lsu_we_i = 1; bus.lsu_waddr_i = 5'd5; bus.lsu_wdata_i = 32'h11;
        drive_ex(0, 5'd6, 32'h22);
        #1;
        chk("coll_ex_ready_c0", 64'(bus.ex_ready_o), 64'd0);
        chk("coll_count", 64'(bus.mc_count_o), 64'd1);
        expect_wr(0, 5'd5, 32'h11);
        step();
        bus.lsu_we_i = 0;
        #1;
        chk("coll_ex_ready_c1", 64'(bus.ex_ready_o), 64'd1);
        chk("coll_grant_lsu", 64'(bus.grant_o), 64'd1);
        expect_wr(0, 5'd6, 32'h22);
        step();
        idle();
        #1;
        chk("coll_grant_ex", 64'(bus.grant_o), 64'd2);
        expect_wr(0, 5'd7, 32'h33);
        step();
        chk("coll_grant_mc", 64'(bus.grant_o), 64'd3);
        step(); step();

        // Starvation: EX streams, MC head wins at cycle 5
        for (int i = 0; i < 7; i++) begin
            int idx;
            idx = (i < 5) ? i : 5;
            idle();
            drive_ex(0, 5'(10 + idx), 32'h100 + 32'(idx));
            if (i == 0) drive_mc(0, 5'd9, 32'hA5);
            #1;
            if (i == 0) chk("starve_mc_ready", 64'(bus.mc_ready_o), 64'd1);
            if (i < 5) begin
                chk("starve_ex_ready_on", 64'(bus.ex_ready_o), 64'd1);
                expect_wr(0, 5'(10 + idx), 32'h100 + 32'(idx));
            end else if (i == 5) begin
                chk("starve_ex_ready_off", 64'(bus.ex_ready_o), 64'd0);
                expect_wr(0, 5'd9, 32'hA5);
            end else begin
                chk("starve_grant_mc", 64'(bus.grant_o), 64'd3);
                expect_wr(0, 5'd15, 32'h105);
            end
            step();
        end
        idle();
        step(); step();

        // FIFO full: depth 2, third MC result held until a pop frees a slot
        for (int i = 0; i < 7; i++) begin
            idle();
            if (i < 4) drive_ex(0, 5'(12 + i), 32'h200 + 32'(i));
            if (i == 0) drive_mc(1, 5'd20, 32'hA0);
            if (i == 1) drive_mc(0, 5'd21, 32'hB0);
            if (i >= 2 && i <= 5) drive_mc(0, 5'd22, 32'hC0);
            #1;
            if (i < 2 || i == 5) chk("full_mc_ready_on", 64'(bus.mc_ready_o), 64'd1);
            if (i >= 2 && i <= 4) chk("full_mc_ready_off", 64'(bus.mc_ready_o), 64'd0);
            if (i < 4) begin
                chk("full_ex_ready", 64'(bus.ex_ready_o), 64'd1);
                expect_wr(0, 5'(12 + i), 32'h200 + 32'(i));
            end
            if (i == 4) expect_wr(1, 5'd20, 32'hA0);
            if (i == 5) expect_wr(0, 5'd21, 32'hB0);
            if (i == 6) expect_wr(0, 5'd22, 32'hC0);
            step();
        end
        idle();
        step(); step();

        // Routing: FP write, then integer x0 accepted without a strobe
        drive_ex(1, 5'd3, 32'hDEADBEEF);
        #1;
        expect_wr(1, 5'd3, 32'hDEADBEEF);
        step();
        drive_ex(0, 5'd0, 32'h55);
        #1;
        chk("x0_ex_ready", 64'(bus.ex_ready_o), 64'd1);
        chk("fp_route_fp_we", 64'(bus.fp_rf_we_o), 64'd1);
        chk("fp_route_rf_we", 64'(bus.rf_we_o), 64'd0);
        step();
        idle();
        #1;
        chk("x0_grant", 64'(bus.grant_o), 64'd2);
        chk("x0_rf_we", 64'(bus.rf_we_o), 64'd0);
        chk("x0_fp_we", 64'(bus.fp_rf_we_o), 64'd0);
        step(); step();

        // Flush with 2 MC entries, EX pending and a concurrent LSU load
        drive_ex(0, 5'd13, 32'h300);
        drive_mc(0, 5'd24, 32'h500);
        #1;
        expect_wr(0, 5'd13, 32'h300);
        step();
        drive_ex(0, 5'd14, 32'h301);
        drive_mc(0, 5'd25, 32'h501);
        #1;
        expect_wr(0, 5'd14, 32'h301);
        step();
        idle();
        drive_ex(0, 5'd15, 32'h302);
        bus.flush_i = 1;
        bus.lsu_we_i = 1; bus.lsu_waddr_i = 5'd4; bus.lsu_wdata_i = 32'h44;
        #1;
        chk("flush_count_before", 64'(bus.mc_count_o), 64'd2);
        chk("flush_mc_ready", 64'(bus.mc_ready_o), 64'd0);
        chk("flush_ex_ready", 64'(bus.ex_ready_o), 64'd0);
        expect_wr(0, 5'd4, 32'h44);
        step();
        idle();
        #1;
        chk("flush_count_after", 64'(bus.mc_count_o), 64'd0);
        chk("flush_grant_lsu", 64'(bus.grant_o), 64'd1);
        repeat (4) step();

        // Reset mid-stream with 2 MC entries buffered and a write in flight
        drive_ex(0, 5'd16, 32'h400);
        drive_mc(0, 5'd26, 32'h500);
        #1;
        expect_wr(0, 5'd16, 32'h400);
        step();
        drive_ex(0, 5'd17, 32'h401);
        drive_mc(0, 5'd27, 32'h501);
        step();
        idle();
        #1;
        chk("pre_reset_rf_we", 64'(bus.rf_we_o), 64'd1);
        chk("pre_reset_count", 64'(bus.mc_count_o), 64'd2);
        rst = 1;
        #1;
        chk("reset_rf_we", 64'(bus.rf_we_o), 64'd0);
        chk("reset_fp_we", 64'(bus.fp_rf_we_o), 64'd0);
        chk("reset_count", 64'(bus.mc_count_o), 64'd0);
        chk("reset_mc_ready", 64'(bus.mc_ready_o), 64'd1);
        chk("reset_grant", 64'(bus.grant_o), 64'd0);
        step(); step();
        rst = 0;
        repeat (8) step();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
